// File: rtl/hazard_pkg.sv
// hazard_pkg: shared FSM state, register-zero constant and counter widths for the hazard controller
package hazard_pkg;
    typedef enum logic {RUN, LOAD_WAIT} hz_state_t;
    localparam logic [4:0] REG_ZERO = 5'd0;
    localparam int LW_CNT_W = 3;
    localparam int MD_CNT_W = 6;
endpackage

// File: rtl/md_occupancy_counter.sv
// md_occupancy_counter: tracks multiply/divide occupancy and flags a start issued while busy
module md_occupancy_counter
    import hazard_pkg::*;
#(
    parameter int MD_CYCLES = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start,
    output logic busy,
    output logic overlap_err
);
    logic [MD_CNT_W-1:0] cnt;
    assign busy = cnt != '0;
    // load on an idle start, count down while busy; a start while busy is ignored but latched as an error
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt         <= '0;
            overlap_err <= 1'b0;
        end else begin
            cnt <= (start && !busy) ? MD_CNT_W'(MD_CYCLES) : busy ? cnt - 1'b1 : '0;
            if (start && busy) overlap_err <= 1'b1;
        end
    end
endmodule

// File: rtl/hazard_controller.sv
// hazard_controller: load-use, mult/div and branch hazard control; HAZARD_PERF_CNT_EN adds stall/flush cycle counters
module hazard_controller
    import hazard_pkg::*;
#(
    parameter int LOAD_BUBBLES = 1,
    parameter int MD_CYCLES    = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [4:0] rs_D,
    input  logic [4:0] rt_D,
    input  logic       uses_rs_D,
    input  logic       uses_rt_D,
    input  logic       md_op_D,
    input  logic       RegWrite_E,
    input  logic       MemtoReg_E,
    input  logic [4:0] write_reg_E,
    input  logic       md_start_E,
    input  logic       branch_taken_E,
    output logic       stall_F,
    output logic       stall_D,
    output logic       flush_D,
    output logic       flush_E,
    output logic       md_busy,
    output logic       md_overlap_err
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [31:0] stall_cycles,
    output logic [31:0] flush_cycles
`endif
);
    hz_state_t           state, state_nx;
    logic [LW_CNT_W-1:0] lw_cnt, lw_cnt_nx;
    logic                lu_hit, md_hit, hold;

    assign lu_hit = RegWrite_E & MemtoReg_E & (write_reg_E != REG_ZERO)
                  & ((uses_rs_D & (rs_D == write_reg_E)) | (uses_rt_D & (rt_D == write_reg_E)));
    assign md_hit  = md_busy & md_op_D;
    assign hold    = (state == LOAD_WAIT) | lu_hit | md_hit;
    assign stall_F = hold & ~branch_taken_E;
    assign stall_D = hold & ~branch_taken_E;
    assign flush_D = branch_taken_E;
    assign flush_E = hold | branch_taken_E;

    md_occupancy_counter #(.MD_CYCLES(MD_CYCLES)) u_md (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (md_start_E),
        .busy        (md_busy),
        .overlap_err (md_overlap_err)
    );

    // load-use FSM state and remaining-bubble counter
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= RUN;
            lw_cnt <= '0;
        end else begin
            state  <= state_nx;
            lw_cnt <= lw_cnt_nx;
        end
    end

    // a taken branch kills the waiting consumer, so it always returns the FSM to RUN
    always_comb begin
        state_nx  = state;
        lw_cnt_nx = lw_cnt;
        if (branch_taken_E) begin
            state_nx  = RUN;
            lw_cnt_nx = '0;
        end else if (state == LOAD_WAIT) begin
            lw_cnt_nx = lw_cnt - 1'b1;
            state_nx  = (lw_cnt == LW_CNT_W'(1)) ? RUN : LOAD_WAIT;
        end else if (lu_hit && LOAD_BUBBLES > 1) begin
            lw_cnt_nx = LW_CNT_W'(LOAD_BUBBLES - 1);
            state_nx  = LOAD_WAIT;
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    // saturating counts of stalled and flushed cycles
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_cycles <= '0;
            flush_cycles <= '0;
        end else begin
            if (stall_D && stall_cycles != '1) stall_cycles <= stall_cycles + 32'd1;
            if (flush_D && flush_cycles != '1) flush_cycles <= flush_cycles + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_hazard_controller.sv
// tb_hazard_controller: directed vector table plus multi-cycle sequences for hazard_controller
module tb_hazard_controller;
    logic       clk = 1'b0;
    logic       rst_n;
    logic [4:0] rs_D, rt_D, write_reg_E;
    logic       uses_rs_D, uses_rt_D, md_op_D, RegWrite_E, MemtoReg_E, md_start_E, branch_taken_E;
    logic       stall_F3, stall_D3, flush_D3, flush_E3, busy3, err3;
    logic       stall_F1, stall_D1, flush_D1, flush_E1, busy1, err1;
`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] sc3, fc3, sc1, fc1;
`endif

    always #5 clk = ~clk;

    hazard_controller #(.LOAD_BUBBLES(3), .MD_CYCLES(8)) u3 (
        .clk(clk), .rst_n(rst_n), .rs_D(rs_D), .rt_D(rt_D), .uses_rs_D(uses_rs_D), .uses_rt_D(uses_rt_D),
        .md_op_D(md_op_D), .RegWrite_E(RegWrite_E), .MemtoReg_E(MemtoReg_E), .write_reg_E(write_reg_E),
        .md_start_E(md_start_E), .branch_taken_E(branch_taken_E), .stall_F(stall_F3), .stall_D(stall_D3),
        .flush_D(flush_D3), .flush_E(flush_E3), .md_busy(busy3), .md_overlap_err(err3)
`ifdef HAZARD_PERF_CNT_EN
        , .stall_cycles(sc3), .flush_cycles(fc3)
`endif
    );

    hazard_controller #(.LOAD_BUBBLES(1), .MD_CYCLES(8)) u1 (
        .clk(clk), .rst_n(rst_n), .rs_D(rs_D), .rt_D(rt_D), .uses_rs_D(uses_rs_D), .uses_rt_D(uses_rt_D),
        .md_op_D(md_op_D), .RegWrite_E(RegWrite_E), .MemtoReg_E(MemtoReg_E), .write_reg_E(write_reg_E),
        .md_start_E(md_start_E), .branch_taken_E(branch_taken_E), .stall_F(stall_F1), .stall_D(stall_D1),
        .flush_D(flush_D1), .flush_E(flush_E1), .md_busy(busy1), .md_overlap_err(err1)
`ifdef HAZARD_PERF_CNT_EN
        , .stall_cycles(sc1), .flush_cycles(fc1)
`endif
    );

    // exp = {stall_F3, stall_D3, flush_D3, flush_E3, md_busy3, md_overlap_err3, stall_D1, flush_E1}
    typedef struct packed {
        logic       rst_n;
        logic [4:0] rs;
        logic       urs;
        logic [4:0] rt;
        logic       urt;
        logic       mdop;
        logic       rw;
        logic       m2r;
        logic [4:0] wr;
        logic       mds;
        logic       br;
        logic [7:0] exp;
    } vec_t;

    vec_t tbl[30];
    vec_t idle;
    int   checks   = 0;
    int   failures = 0;
    int   n3, n1;

    function automatic vec_t v(input logic r, input logic [4:0] rs, input logic urs, input logic [4:0] rt,
                               input logic urt, input logic mdop, input logic rw, input logic m2r,
                               input logic [4:0] wr, input logic mds, input logic br, input logic [7:0] exp);
        vec_t x;
        x = '{r, rs, urs, rt, urt, mdop, rw, m2r, wr, mds, br, exp};
        return x;
    endfunction

    task automatic drive(input vec_t x);
        @(posedge clk);
        #1;
        rst_n          = x.rst_n;
        rs_D           = x.rs;
        uses_rs_D      = x.urs;
        rt_D           = x.rt;
        uses_rt_D      = x.urt;
        md_op_D        = x.mdop;
        RegWrite_E     = x.rw;
        MemtoReg_E     = x.m2r;
        write_reg_E    = x.wr;
        md_start_E     = x.mds;
        branch_taken_E = x.br;
    endtask

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", nm, act, exp);
        end
    endtask

    initial begin
        idle = v(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 8'h00);
        tbl[0]  = v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 8'b0000_0000);
        tbl[1]  = v(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 8'b0000_0000);
        tbl[2]  = v(1, 5, 1, 0, 0, 0, 1, 1, 5, 0, 0, 8'b1101_0011);
        tbl[3]  = v(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 8'b1101_0000);
        tbl[4]  = v(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 8'b1101_0000);
        tbl[5]  = v(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 8'b0000_0000);
        tbl[6]  = v(1, 0, 1, 0, 0, 0, 1, 1, 0, 0, 0, 8'b0000_0000);
        tbl[7]  = v(1, 0, 0, 7, 0, 0, 1, 1, 7, 0, 0, 8'b0000_0000);
        tbl[8]  = v(1, 0, 0, 7, 1, 0, 1, 1, 7, 0, 0, 8'b1101_0011);
        tbl[9]  = v(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 8'b1101_0000);
        tbl[10] = v(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 8'b0011_0001);
        tbl[11] = v(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 8'b0000_0000);
        tbl[12] = v(1, 5, 1, 0, 0, 0, 1, 0, 5, 0, 0, 8'b0000_0000);
        tbl[13] = v(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 8'b0000_0000);
        tbl[14] = v(1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 8'b1101_1011);
        tbl[15] = v(1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 8'b1101_1011);
        tbl[16] = v(1, 0, 0, 0, 0, 1, 0, 0, 0, 1, 0, 8'b1101_1011);
        tbl[17] = v(1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 8'b1101_1111);
        tbl[18] = v(1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 8'b0011_1101);
        tbl[19] = v(1, 5, 1, 0, 0, 1, 1, 1, 5, 0, 0, 8'b1101_1111);
        tbl[20] = v(1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 8'b1101_1111);
        tbl[21] = v(1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 8'b1101_1111);
        tbl[22] = v(1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 8'b0000_0100);
        tbl[23] = v(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 8'b0000_0100);
        tbl[24] = v(1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 8'b1101_1111);
        tbl[25] = v(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 8'b1101_1111);
        tbl[26] = v(1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 8'b0000_0000);
        tbl[27] = v(1, 5, 1, 0, 0, 0, 1, 1, 5, 0, 0, 8'b1101_0011);
        tbl[28] = v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 8'b1101_0000);
        tbl[29] = v(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 8'b0000_0000);

        drive(v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 8'h00));
        drive(v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 8'h00));

        for (int i = 0; i < 30; i++) begin
            drive(tbl[i]);
            #2;
            check($sformatf("row%0d", i),
                  {24'd0, stall_F3, stall_D3, flush_D3, flush_E3, busy3, err3, stall_D1, flush_E1},
                  {24'd0, tbl[i].exp});
        end

        drive(v(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 8'h00));
        #2;
        check("md_busy_start_cycle", {31'd0, busy3}, 32'd0);
        n3 = 0;
        for (int i = 0; i < 40; i++) begin
            drive(idle);
            #2;
            if (busy3) n3++;
        end
        check("md_busy_len", n3, 32'd8);
        check("md_no_overlap", {31'd0, err3}, 32'd0);

        drive(v(1, 9, 1, 0, 0, 0, 1, 1, 9, 0, 0, 8'h00));
        #2;
        n3 = int'(stall_D3);
        n1 = int'(stall_D1);
        for (int i = 0; i < 20; i++) begin
            drive(idle);
            #2;
            if (stall_D3) n3++;
            if (stall_D1) n1++;
        end
        check("lu_bubbles_3", n3, 32'd3);
        check("lu_bubbles_1", n1, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
